prio_encoder_rr: RTL
====================

# prio_encoder_rr

Parametrised, registered N-to-log2(N) encoder with valid/ready handshake on both sides. It replaces fixed 4-to-2 one-hot encoders wherever a request vector must be turned into an index. It adds selectable LSB, MSB or round-robin priority, zero and multi-hot flags, and a saturating multi-hot event counter. It sits between request producers (interrupt lines, arbiters) and index consumers.

## Interface
- `N`, default 8: request vector width; power of two, 2..64.
- `MODE`, default 0: 0 = lowest index wins, 1 = highest index wins, 2 = round-robin.
- `CNT_W`, default 8: width of the multi-hot event counter.
- Derived localparam `W = $clog2(N)`: index width.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `req`, in, N: request vector, sampled on an input handshake.
- `in_valid`, in, 1: `req` is valid.
- `in_ready`, out, 1: block can accept `req`.
- `idx`, out, W: encoded winning index.
- `grant`, out, N: one-hot form of `idx`; all zero when `zero` is set.
- `zero`, out, 1: the accepted `req` was all zeros.
- `multi`, out, 1: the accepted `req` had more than one bit set.
- `out_valid`, out, 1: `idx`, `grant`, `zero` and `multi` are valid.
- `out_ready`, in, 1: consumer takes the output.
- `multi_cnt`, out, CNT_W: saturating count of accepted multi-hot vectors.

## Operation
- Input handshake: accept when `in_valid && in_ready`. `in_ready = !out_valid || out_ready`, a combinational path from `out_ready`.
- On accept, the selection is computed from `req` and registered into `idx`, `grant`, `zero` and `multi`. `out_valid` is set to 1.
- Output handshake: a transfer occurs when `out_valid && out_ready`. If there is no new accept in that cycle, `out_valid` goes to 0.
- Output stability: while `out_valid && !out_ready`, all outputs hold stable.
- Selection:
  - MODE 0: lowest set bit wins.
  - MODE 1: highest set bit wins.
  - MODE 2: search upward from pointer `ptr`, wrapping N-1 to 0; the first set bit wins.
- Round-robin pointer update:
  - On an accept with nonzero `req` in MODE 2: `ptr <= (idx_next + 1) mod N`.
  - `ptr` is unchanged on a zero `req`, when there is no accept, and in MODES 0 and 1.
- Zero request: `zero=1`, `idx=0`, `grant=0`, `multi=0`. `out_valid` is still asserted, because the consumer sees the event.
- `multi` is computed from `req` only; it is independent of MODE.
- `multi_cnt` increments on each accepted multi-hot `req` and saturates at 2^CNT_W-1, with no wrap.
- Reset values: `out_valid=0`, `idx=0`, `grant=0`, `zero=0`, `multi=0`, `multi_cnt=0`, `ptr=0`. `in_ready` is 1 during and after reset.
- Reset mid-operation: any pending output is discarded without a handshake, and `ptr` returns to 0.

## Timing
- Latency: 1 cycle. A `req` accepted at edge k appears with `out_valid=1` after edge k.
- Throughput: 1 vector per cycle when `out_ready` is held high.
- Simultaneous output transfer and new accept in one cycle: the output register loads the new result, and `out_valid` stays 1.
- `ptr` and `multi_cnt` update on the same edge as the accept.
- No combinational path from `req` or `in_valid` to any output.

## Structure
- Shared package `prio_enc_pkg` holds:
  - MODE constants `PE_LSB=0`, `PE_MSB=1`, `PE_RR=2`.
  - A function `onehot_to_idx`.
- One sub-module, `prio_pick`: combinational. Its inputs are `req`, `ptr` and MODE; its outputs are `idx_next`, `grant_next`, `zero_next` and `multi_next`.
  - Round-robin is done by rotating `req` right by `ptr`, performing an LSB pick, then adding `ptr` mod N.
- The top level holds the output register, `ptr`, `multi_cnt` and the handshake logic.

## Test plan
- Reset, then MODE 0, N=8: `req=8'b0010_1000` → next cycle `idx=3`, `grant=8'h08`, `multi=1`, `multi_cnt=1`.
- MODE 1, same `req` → `idx=5`, `grant=8'h20`. Then `req=8'h00` → `zero=1`, `idx=0`, `grant=0`.
- MODE 2, `req=8'hFF` held for 10 cycles with `out_ready=1` → `idx` sequence 0,1,…,7,0,1; one result per cycle.
- MODE 2, `req=8'b1000_0001` after a grant at index 7 → `ptr=0`, `idx=0`. Next vector: `idx=7`.
- Backpressure: `out_ready=0` for 3 cycles with new `req` offered → `in_ready=0`, outputs stable, `ptr` unchanged. Release → accept in the same cycle as the transfer, no bubble.
- With CNT_W=2, 5 multi-hot accepts → `multi_cnt` saturates at 3. Asserting `rst` mid-stream clears `out_valid` and `multi_cnt` to 0 asynchronously.

Source files
------------

// File: rtl/prio_enc_pkg.sv
// Shared constants and helpers for the priority encoder family.
package prio_enc_pkg;

  // Selection policies
  localparam int PE_LSB = 0;  // lowest set bit wins
  localparam int PE_MSB = 1;  // highest set bit wins
  localparam int PE_RR  = 2;  // round-robin from a rotating pointer

  // Convert a one-hot (or all-zero) vector of up to 64 bits into its index.
  // An all-zero input yields 0; callers flag that case separately.
  function automatic logic [5:0] onehot_to_idx(input logic [63:0] oh);
    logic [5:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      if (oh[i]) r = r | 6'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational winner selection: LSB, MSB or round-robin pick plus zero/multi flags.
module prio_pick
  import prio_enc_pkg::*;
#(
  parameter int N    = 8,
  parameter int MODE = PE_LSB
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] idx_next,
  output logic [N-1:0]         grant_next,
  output logic                 zero_next,
  output logic                 multi_next
);

  localparam int W = $clog2(N);

  logic [N-1:0]   one_n;
  logic [N-1:0]   lsb_oh;
  logic [N-1:0]   req_rev;
  logic [N-1:0]   rev_oh;
  logic [N-1:0]   msb_oh;
  logic [2*N-1:0] req_dbl_sh;
  logic [N-1:0]   req_rot;
  logic [N-1:0]   rot_oh;
  logic [N-1:0]   sel_oh;
  logic [5:0]     idx_full;
  logic [W-1:0]   idx_raw;
  logic [W-1:0]   idx_pick;
  logic [N-1:0]   unused_rot_hi;
  logic [5:0]     unused_idx_full;

  assign one_n = {{(N-1){1'b0}}, 1'b1};

  // Isolate the lowest set bit: x & -x
  assign lsb_oh = req & (~req + one_n);

  // Highest set bit: bit-reverse, isolate lowest, reverse back
  for (genvar gi = 0; gi < N; gi++) begin : g_rev
    assign req_rev[gi] = req[N-1-gi];
    assign msb_oh[gi]  = rev_oh[N-1-gi];
  end
  assign rev_oh = req_rev & (~req_rev + one_n);

  // Round-robin: rotate right by ptr so the search starts at bit 0, pick LSB,
  // then add ptr back (W-bit add wraps modulo N since N is a power of two)
  assign req_dbl_sh    = {req, req} >> ptr;
  assign req_rot       = req_dbl_sh[N-1:0];
  assign unused_rot_hi = req_dbl_sh[2*N-1:N];
  assign rot_oh        = req_rot & (~req_rot + one_n);

  // Choose the one-hot for the configured policy and encode it
  always_comb begin
    sel_oh = lsb_oh;
    if (MODE == PE_MSB) sel_oh = msb_oh;
    else if (MODE == PE_RR) sel_oh = rot_oh;
  end

  assign idx_full        = onehot_to_idx(64'(sel_oh));
  assign idx_raw         = idx_full[W-1:0];
  assign unused_idx_full = idx_full;
  assign idx_pick        = (MODE == PE_RR) ? idx_raw + ptr : idx_raw;

  // Flags come straight from req; a zero request forces index and grant to 0
  assign zero_next  = ~|req;
  assign multi_next = |(req & (req - one_n));
  assign idx_next   = zero_next ? '0 : idx_pick;
  assign grant_next = zero_next ? '0 : (one_n << idx_pick);

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered N-to-log2(N) priority encoder with valid/ready on both sides,
// round-robin pointer and a saturating multi-hot event counter.
module prio_encoder_rr
  import prio_enc_pkg::*;
#(
  parameter int N     = 8,
  parameter int MODE  = PE_LSB,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [$clog2(N)-1:0] idx,
  output logic [N-1:0]         grant,
  output logic                 zero,
  output logic                 multi,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_W-1:0]     multi_cnt
);

  localparam int W = $clog2(N);

  logic [W-1:0]     idx_next;
  logic [N-1:0]     grant_next;
  logic             zero_next;
  logic             multi_next;
  logic             accept;

  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     idx_q, idx_d;
  logic [N-1:0]     grant_q, grant_d;
  logic             zero_q, zero_d;
  logic             multi_q, multi_d;
  logic [W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0] multi_cnt_q, multi_cnt_d;

  prio_pick #(
    .N    (N),
    .MODE (MODE)
  ) u_pick (
    .req        (req),
    .ptr        (ptr_q),
    .idx_next   (idx_next),
    .grant_next (grant_next),
    .zero_next  (zero_next),
    .multi_next (multi_next)
  );

  // The slot is free when empty or being drained this cycle
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Next-state for output register, pointer and counter
  always_comb begin
    out_valid_d = out_valid_q;
    idx_d       = idx_q;
    grant_d     = grant_q;
    zero_d      = zero_q;
    multi_d     = multi_q;
    ptr_d       = ptr_q;
    multi_cnt_d = multi_cnt_q;
    if (accept) begin
      out_valid_d = 1'b1;
      idx_d       = idx_next;
      grant_d     = grant_next;
      zero_d      = zero_next;
      multi_d     = multi_next;
      if (MODE == PE_RR && !zero_next) ptr_d = idx_next + W'(1);
      if (multi_next && multi_cnt_q != {CNT_W{1'b1}}) multi_cnt_d = multi_cnt_q + CNT_W'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset discards any pending result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      idx_q       <= '0;
      grant_q     <= '0;
      zero_q      <= 1'b0;
      multi_q     <= 1'b0;
      ptr_q       <= '0;
      multi_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      idx_q       <= idx_d;
      grant_q     <= grant_d;
      zero_q      <= zero_d;
      multi_q     <= multi_d;
      ptr_q       <= ptr_d;
      multi_cnt_q <= multi_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign idx       = idx_q;
  assign grant     = grant_q;
  assign zero      = zero_q;
  assign multi     = multi_q;
  assign multi_cnt = multi_cnt_q;

endmodule
